// File: rtl/tff_mod_counter_ctrl_pkg.sv
// Shared types, defaults and toggle-vector helpers for the
// modulo-N T flip-flop counter controller.
package tff_mod_counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DEF_MIN_MOD = 2;
    localparam int FN_W        = 32;

    // Helpers work on a wide word; callers zero-extend and truncate.
    function automatic logic [FN_W-1:0] up_toggle(
        input logic [FN_W-1:0] q,
        input logic [FN_W-1:0] last
    );
        return (q == last) ? q : (q ^ (q + 32'd1));
    endfunction

    function automatic logic [FN_W-1:0] down_toggle(
        input logic [FN_W-1:0] q,
        input logic [FN_W-1:0] last
    );
        return (q == '0) ? last : (q ^ (q - 32'd1));
    endfunction

endpackage

// File: rtl/tff_mod_counter_ctrl_tff_bank.sv
// Bank of WIDTH toggle flip-flops with complementary outputs.
// Each bit flips on a rising clock edge when its T input is set.
module tff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] T_vec,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qb
);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Q <= '0;
        end else begin
            Q <= Q ^ T_vec;
        end
    end

    assign Qb = ~Q;

endmodule

// File: rtl/tff_mod_counter_ctrl.sv
// Start/stop controller driving a T flip-flop bank as a
// programmable modulo-N up/down counter.
module tff_mod_counter_ctrl
    import tff_mod_counter_ctrl_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MIN_MOD = DEF_MIN_MOD
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Up,
    input  logic [WIDTH-1:0] Mod,
    input  logic             Count_En,
    output logic [WIDTH-1:0] T_vec,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qb,
    output logic             Tc,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_MOD);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] mod_r;
    logic [WIDTH-1:0] last;
    logic [WIDTH-1:0] init;
    logic             up_r;
    logic             stop_pend;
    logic             err_r;
    logic             start_bad;
    logic             at_term;
    logic             tc;

    tff_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .Clock  (Clock),
        .Resetn (Resetn),
        .T_vec  (T_vec),
        .Q      (Q),
        .Qb     (Qb)
    );

    assign last      = mod_r - ONE;
    assign start_bad = Mod < MIN_W;
    assign init      = Up ? '0 : (Mod - ONE);
    assign at_term   = up_r ? (Q == last) : (Q == '0);
    assign tc        = (state == RUN) && Count_En && at_term;

    // Toggling Q ^ target loads the target value in a single edge.
    always_comb begin
        T_vec = '0;
        unique case (state)
            IDLE: begin
                if (Start && !start_bad) begin
                    T_vec = Q ^ init;
                end
            end
            RUN: begin
                if (Count_En) begin
                    if (up_r) begin
                        T_vec = WIDTH'(up_toggle(FN_W'(Q), FN_W'(last)));
                    end else begin
                        T_vec = WIDTH'(down_toggle(FN_W'(Q), FN_W'(last)));
                    end
                end
            end
            default: T_vec = '0;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= IDLE;
            mod_r     <= '0;
            up_r      <= 1'b1;
            stop_pend <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            err_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        if (start_bad) begin
                            err_r <= 1'b1;
                        end else begin
                            mod_r <= Mod;
                            up_r  <= Up;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // A stop arriving on the wrap cycle itself counts too.
                    if (tc && (stop_pend || Stop)) begin
                        state     <= DONE;
                        stop_pend <= 1'b0;
                    end else if (Stop) begin
                        stop_pend <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Tc   = tc;
    assign Busy = (state == RUN);
    assign Done = (state == DONE);
    assign Err  = err_r;

endmodule

// File: tb/tb_tff_mod_counter_ctrl.sv
// Randomised and directed bench for tff_mod_counter_ctrl against
// an arithmetic modulo-N reference model.
module tb_tff_mod_counter_ctrl;

    logic       Clock;
    logic       Resetn;
    logic       Start;
    logic       Stop;
    logic       Up;
    logic [3:0] Mod;
    logic       Count_En;
    logic [3:0] T_vec;
    logic [3:0] Q;
    logic [3:0] Qb;
    logic       Tc;
    logic       Busy;
    logic       Done;
    logic       Err;

    int checks;
    int failures;

    // model: 0 = idle, 1 = run, 2 = done
    int  m_state;
    int  m_q;
    int  m_mod;
    int  m_up;
    int  m_pend;
    int  m_err;
    int  m_next;
    bit  e_tc;
    logic [15:0] exp_vec;
    logic [15:0] act_vec;

    tff_mod_counter_ctrl #(
        .WIDTH   (4),
        .MIN_MOD (2)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Start    (Start),
        .Stop     (Stop),
        .Up       (Up),
        .Mod      (Mod),
        .Count_En (Count_En),
        .T_vec    (T_vec),
        .Q        (Q),
        .Qb       (Qb),
        .Tc       (Tc),
        .Busy     (Busy),
        .Done     (Done),
        .Err      (Err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    assign act_vec = {Q, Qb, T_vec, Tc, Busy, Done, Err};

    task automatic model_reset();
        m_state = 0;
        m_q     = 0;
        m_mod   = 0;
        m_up    = 1;
        m_pend  = 0;
        m_err   = 0;
    endtask

    task automatic model_eval();
        int nq;
        nq   = m_q;
        e_tc = 1'b0;
        if (m_state == 0) begin
            if (Start && int'(Mod) >= 2) nq = Up ? 0 : int'(Mod) - 1;
        end else if (m_state == 1) begin
            if (Count_En) begin
                e_tc = m_up ? (m_q == m_mod - 1) : (m_q == 0);
                nq = m_up ? (m_q + 1) % m_mod : (m_q + m_mod - 1) % m_mod;
            end
        end
        m_next  = nq;
        exp_vec = {4'(m_q), ~4'(m_q), 4'(m_q ^ nq), e_tc,
                   m_state == 1, m_state == 2, m_err == 1};
    endtask

    task automatic model_update();
        int nerr;
        nerr = 0;
        if (m_state == 0) begin
            if (Start) begin
                if (int'(Mod) < 2) nerr = 1;
                else begin
                    m_mod   = int'(Mod);
                    m_up    = int'(Up);
                    m_state = 1;
                end
            end
        end else if (m_state == 1) begin
            if (e_tc && (m_pend == 1 || Stop)) begin
                m_state = 2;
                m_pend  = 0;
            end else if (Stop) begin
                m_pend = 1;
            end
        end else begin
            m_state = 0;
        end
        m_err = nerr;
        m_q   = m_next;
    endtask

    task automatic apply(input bit st, input bit sp, input bit u,
                         input logic [3:0] m, input bit en);
        @(negedge Clock);
        Start    = st;
        Stop     = sp;
        Up       = u;
        Mod      = m;
        Count_En = en;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge Clock);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        Start = 0; Stop = 0; Up = 1; Mod = 0; Count_En = 0;
        model_reset();
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        Start = 0; Stop = 0; Up = 1; Mod = 0; Count_En = 0;
        model_reset();
        #2;
        checks++;
        if ({Q, Qb, Tc, Busy, Done, Err} !== {4'h0, 4'hF, 4'h0}) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h",
                     {Q, Qb, Tc, Busy, Done, Err}, {4'h0, 4'hF, 4'h0});
        end
        @(negedge Clock);
        Resetn = 1'b1;
        apply(1, 0, 1, 4'd10, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 4'd0, 1);
            tick();
        end
        checks++;
        if (Q !== 4'd3) begin
            failures++;
            $display("FAIL pre_reset_q got=%0d want=3", Q);
        end
        Resetn = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({Q, Busy, Tc, Done} !== {4'd0, 3'b000}) begin
            failures++;
            $display("FAIL async_reset got=%h want=%h",
                     {Q, Busy, Tc, Done}, {4'd0, 3'b000});
        end
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    task automatic test_up_mod10();
        do_reset();
        apply(1, 0, 1, 4'd10, 1);
        tick();
        for (int i = 0; i < 11; i++) begin
            apply(0, 0, 1'($urandom), 4'($urandom), 1);
            checks++;
            if (act_vec !== exp_vec) begin
                failures++;
                $display("FAIL up10_cycle%0d got=%h want=%h", i, act_vec, exp_vec);
            end
            checks++;
            if (Q !== 4'(i % 10) || Tc !== (i == 9)) begin
                failures++;
                $display("FAIL up10_seq%0d got q=%0d tc=%b want q=%0d tc=%b",
                         i, Q, Tc, i % 10, i == 9);
            end
            if (i == 7) begin
                checks++;
                if (T_vec !== 4'b1111) begin
                    failures++;
                    $display("FAIL up10_t7to8 got=%b want=1111", T_vec);
                end
            end
            tick();
        end
    endtask

    task automatic test_down_mod6();
        int want;
        do_reset();
        apply(1, 0, 0, 4'd6, 1);
        tick();
        for (int i = 0; i < 8; i++) begin
            apply(0, 0, 1, 4'd3, 1);
            want = 5 - (i % 6);
            checks++;
            if (act_vec !== exp_vec || Q !== 4'(want)) begin
                failures++;
                $display("FAIL down6_cycle%0d got=%h want=%h q_want=%0d",
                         i, act_vec, exp_vec, want);
            end
            if (want == 0) begin
                checks++;
                if (T_vec !== 4'b0101 || Tc !== 1'b1) begin
                    failures++;
                    $display("FAIL down6_wrap got t=%b tc=%b want t=0101 tc=1",
                             T_vec, Tc);
                end
            end
            tick();
        end
    endtask

    task automatic test_stop();
        bit seen;
        do_reset();
        apply(1, 0, 1, 4'd10, 1);
        tick();
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            apply(0, Q == 4'd4, 1, 4'd10, 1);
            checks++;
            if (act_vec !== exp_vec) begin
                failures++;
                $display("FAIL stop_cycle%0d got=%h want=%h", i, act_vec, exp_vec);
            end
            if (Done) begin
                seen = 1;
                checks++;
                if (Q !== 4'd0 || Busy !== 1'b0 || i != 10) begin
                    failures++;
                    $display("FAIL stop_done got q=%0d busy=%b cyc=%0d want q=0 busy=0 cyc=10",
                             Q, Busy, i);
                end
            end
            tick();
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL stop_timeout got=no_done want=done");
        end
        apply(0, 0, 1, 4'd10, 1);
        checks++;
        if ({Q, Busy, Done} !== {4'd0, 2'b00} || act_vec !== exp_vec) begin
            failures++;
            $display("FAIL stop_idle got=%h want=%h", act_vec, exp_vec);
        end
        tick();
    endtask

    task automatic test_err();
        do_reset();
        apply(1, 0, 1, 4'd1, 1);
        checks++;
        if (T_vec !== 4'd0 || Err !== 1'b0) begin
            failures++;
            $display("FAIL err_pre got t=%b err=%b want t=0000 err=0", T_vec, Err);
        end
        tick();
        apply(0, 0, 1, 4'd1, 1);
        checks++;
        if ({Err, Busy, Q} !== {2'b10, 4'd0} || act_vec !== exp_vec) begin
            failures++;
            $display("FAIL err_pulse got=%h want=%h", act_vec, exp_vec);
        end
        tick();
        apply(0, 0, 1, 4'd1, 1);
        checks++;
        if (Err !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL err_clear got err=%b busy=%b want 0 0", Err, Busy);
        end
        tick();
    endtask

    task automatic test_count_en();
        bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        int want;
        do_reset();
        apply(1, 0, 1, 4'd10, 1);
        tick();
        want = 0;
        for (int i = 0; i < 7; i++) begin
            apply(0, 0, 1, 4'd10, pat[i]);
            checks++;
            if (act_vec !== exp_vec || Q !== 4'(want)) begin
                failures++;
                $display("FAIL count_en%0d got=%h want=%h q_want=%0d",
                         i, act_vec, exp_vec, want);
            end
            if (pat[i]) want = want + 1;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int want;
        do_reset();
        apply(1, 0, 1, 4'd10, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 1, 4'd10, 1);
            tick();
        end
        want = 4;
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 0, 4'd5, 1);
            checks++;
            if (act_vec !== exp_vec || Q !== 4'(want)) begin
                failures++;
                $display("FAIL restart_ignored%0d got=%h want=%h q_want=%0d",
                         i, act_vec, exp_vec, want);
            end
            want++;
            tick();
        end
    endtask

    task automatic test_random();
        bit st;
        bit sp;
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 11) == 0);
            apply(st, sp, 1'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
            checks++;
            if (act_vec !== exp_vec) begin
                failures++;
                $display("FAIL random%0d got=%h want=%h", i, act_vec, exp_vec);
            end
            tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_up_mod10();
        test_down_mod6();
        test_stop();
        test_err();
        test_count_en();
        test_back_to_back();
        do_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
